// File: rtl/alien_hit_scanner_if.sv
// alien_hit_scanner_if: missile/formation inputs and per-frame scan results
interface alien_hit_scanner_if #(parameter int N = 55);
  logic frame_clk, pm_exist, level_restart;
  logic [9:0] pmX, pmY, grid_x, grid_y;
  logic [N-1:0] alive;
  logic collided, scan_done, all_dead;
  logic [5:0] hit_index;
  logic [15:0] score;
  modport master (
    output frame_clk, pm_exist, level_restart, pmX, pmY, grid_x, grid_y,
    input alive, collided, scan_done, all_dead, hit_index, score
  );
  modport slave (
    input frame_clk, pm_exist, level_restart, pmX, pmY, grid_x, grid_y,
    output alive, collided, scan_done, all_dead, hit_index, score
  );
endinterface

// File: rtl/alien_hit_scanner.sv
// alien_hit_scanner: per-frame missile vs formation hit scan with scoring; ROW_POINTS_EN enables per-row points
module alien_hit_scanner #(
  parameter int ROWS = 5,
  parameter int COLS = 11,
  parameter int ALIEN_W = 16,
  parameter int ALIEN_H = 16,
  parameter int X_PITCH = 32,
  parameter int Y_PITCH = 24,
  parameter int PM_W = 4,
  parameter int PM_H = 8
) (
  input logic Clk,
  input logic Reset,
  alien_hit_scanner_if.slave bus
);
  localparam int N = ROWS * COLS;
  typedef enum logic [1:0] {IDLE, SCAN, HIT, DONE} state_t;
  state_t state, state_n;
  logic sync1, sync2, edge_q, start, overlap, hit_now, last, wrap, restore, restart_pending;
  logic [9:0] lx, ly, gx;
  logic [10:0] ax, ay;
  logic [2:0] row;
  logic [3:0] col;
  logic [5:0] idx, hit_index;
  logic [N-1:0] alive;
  logic collided, all_dead;
  logic [15:0] score;
  logic [4:0] pts;
  logic [16:0] sum;
  assign start = sync2 && !edge_q;
  assign overlap = ({1'b0, lx} <= ax + 11'(ALIEN_W - 1)) && (ax <= {1'b0, lx} + 11'(PM_W - 1)) &&
                   ({1'b0, ly} <= ay + 11'(ALIEN_H - 1)) && (ay <= {1'b0, ly} + 11'(PM_H - 1));
  assign hit_now = alive[idx] && overlap;
  assign last = idx == 6'(N - 1);
  assign wrap = col == 4'(COLS - 1);
  assign restore = (state == IDLE && bus.level_restart) ||
                   (state == DONE && (bus.level_restart || restart_pending));
`ifdef ROW_POINTS_EN
  assign pts = row == 3'd0 ? 5'd30 : row <= 3'd2 ? 5'd20 : 5'd10;
`else
  assign pts = 5'd10;
`endif
  assign sum = {1'b0, score} + {12'd0, pts};
  assign bus.alive = alive;
  assign bus.collided = collided;
  assign bus.hit_index = hit_index;
  assign bus.score = score;
  assign bus.all_dead = all_dead;
  assign bus.scan_done = state == DONE;
  // state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else state <= state_n;
  end
  // next-state: first live overlapping alien in index order ends the scan via HIT
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? (bus.pm_exist ? SCAN : DONE) : IDLE;
      SCAN: state_n = hit_now ? HIT : last ? DONE : SCAN;
      HIT: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // frame sync, scan counters, kill/score update and revive handling
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {sync1, sync2, edge_q, restart_pending, collided, all_dead} <= '0;
      {lx, ly, gx, ax, ay, row, col, idx} <= '0;
      hit_index <= '0;
      score <= '0;
      alive <= '1;
    end else begin
      sync1 <= bus.frame_clk;
      sync2 <= sync1;
      edge_q <= sync2;
      restart_pending <= (state == SCAN || state == HIT) && (bus.level_restart || restart_pending);
      if (state == IDLE && start) begin
        {lx, ly, gx} <= {bus.pmX, bus.pmY, bus.grid_x};
        {ax, ay} <= {1'b0, bus.grid_x, 1'b0, bus.grid_y};
        {row, col, idx} <= '0;
        collided <= 1'b0;
      end
      if (state == SCAN && !hit_now) begin
        idx <= idx + 6'd1;
        col <= wrap ? 4'd0 : col + 4'd1;
        row <= wrap ? row + 3'd1 : row;
        ax <= wrap ? {1'b0, gx} : ax + 11'(X_PITCH);
        ay <= wrap ? ay + 11'(Y_PITCH) : ay;
      end
      if (state == HIT) begin
        alive[idx] <= 1'b0;
        collided <= 1'b1;
        hit_index <= idx;
        score <= sum[16] ? 16'hFFFF : sum[15:0];
      end
      if (restore) alive <= '1;
      if (restore) all_dead <= 1'b0;
      else if (state == DONE) all_dead <= alive == '0;
    end
  end
endmodule

// File: tb/tb_alien_hit_scanner.sv
// tb_alien_hit_scanner: directed checks of hit scan, timing, scoring, saturation, reset and revive
module tb_alien_hit_scanner;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int n;
  logic [54:0] ea;
  logic [15:0] es;
  logic [16:0] t;
  alien_hit_scanner_if bus();
  alien_hit_scanner dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #10 Clk = ~Clk;
`ifdef ROW_POINTS_EN
  localparam int P0 = 30;
  localparam int P12 = 20;
`else
  localparam int P0 = 10;
  localparam int P12 = 10;
`endif
  function automatic int pts(input int r);
    return r == 0 ? P0 : r <= 2 ? P12 : 10;
  endfunction
  task automatic add(input int p);
    t = 17'(es) + 17'(p);
    es = t > 17'h0FFFF ? 16'hFFFF : t[15:0];
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic e, output int cnt);
    @(negedge Clk);
    bus.pmX = x;
    bus.pmY = y;
    bus.pm_exist = e;
    bus.frame_clk = 1'b1;
    cnt = 0;
    while (!bus.scan_done && cnt < 200) begin
      @(negedge Clk);
      cnt++;
      if (cnt == 2) bus.frame_clk = 1'b0;
    end
    @(negedge Clk);
  endtask
  initial begin
    bus.frame_clk = 1'b0;
    bus.pm_exist = 1'b0;
    bus.level_restart = 1'b0;
    bus.pmX = '0;
    bus.pmY = '0;
    bus.grid_x = 10'd100;
    bus.grid_y = 10'd50;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    ea = '1;
    es = '0;
    chk("rst_alive", bus.alive, ea);
    chk("rst_collided", bus.collided, 0);
    chk("rst_hit_index", bus.hit_index, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_scan_done", bus.scan_done, 0);
    chk("rst_all_dead", bus.all_dead, 0);
    frame(10'd104, 10'd60, 1'b1, n);
    ea[0] = 1'b0;
    add(P0);
    chk("t1_latency", n, 5);
    chk("t1_collided", bus.collided, 1);
    chk("t1_hit_index", bus.hit_index, 0);
    chk("t1_alive", bus.alive, ea);
    chk("t1_score", bus.score, es);
    chk("t1_done_single", bus.scan_done, 0);
    frame(10'd117, 10'd60, 1'b1, n);
    chk("t3_latency", n, 58);
    chk("t3_collided", bus.collided, 0);
    chk("t3_alive", bus.alive, ea);
    frame(10'd104, 10'd60, 1'b1, n);
    chk("t4_dead_latency", n, 58);
    chk("t4_dead_collided", bus.collided, 0);
    chk("t4_dead_score", bus.score, es);
    frame(10'd415, 10'd150, 1'b1, n);
    chk("t2_415_latency", n, 58);
    chk("t2_415_collided", bus.collided, 0);
    frame(10'd417, 10'd150, 1'b1, n);
    ea[54] = 1'b0;
    add(10);
    chk("t2_417_latency", n, 59);
    chk("t2_417_collided", bus.collided, 1);
    chk("t2_417_hit_index", bus.hit_index, 54);
    chk("t2_417_alive", bus.alive, ea);
    chk("t2_417_score", bus.score, es);
    frame(10'd418, 10'd150, 1'b1, n);
    chk("t2_418_dead_collided", bus.collided, 0);
    bus.level_restart = 1'b1;
    @(negedge Clk);
    bus.level_restart = 1'b0;
    ea = '1;
    chk("t4_restart_alive", bus.alive, ea);
    frame(10'd113, 10'd60, 1'b1, n);
    ea[0] = 1'b0;
    add(P0);
    chk("t4_first_latency", n, 5);
    chk("t4_first_hit_index", bus.hit_index, 0);
    chk("t4_first_alive", bus.alive, ea);
    chk("t4_first_score", bus.score, es);
    frame(10'd136, 10'd60, 1'b0, n);
    chk("t5_noexist_latency", n, 3);
    chk("t5_noexist_collided", bus.collided, 0);
    chk("t5_noexist_alive", bus.alive, ea);
    chk("t5_noexist_score", bus.score, es);
    bus.level_restart = 1'b1;
    force dut.score = 16'hFFF0;
    @(negedge Clk);
    bus.level_restart = 1'b0;
    release dut.score;
    ea = '1;
    es = 16'hFFF0;
    frame(10'd104, 10'd60, 1'b1, n);
    ea[0] = 1'b0;
    add(P0);
    chk("t5_sat1_score", bus.score, es);
    frame(10'd136, 10'd60, 1'b1, n);
    ea[1] = 1'b0;
    add(P0);
    chk("t5_sat2_hit_index", bus.hit_index, 1);
    chk("t5_sat2_score", bus.score, 16'hFFFF);
    chk("t5_sat2_alive", bus.alive, ea);
    @(negedge Clk);
    bus.pmX = 10'd392;
    bus.pmY = 10'd78;
    bus.pm_exist = 1'b1;
    bus.frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (19) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    ea = '1;
    es = '0;
    chk("t6_rst_alive", bus.alive, ea);
    chk("t6_rst_score", bus.score, 0);
    chk("t6_rst_collided", bus.collided, 0);
    chk("t6_rst_hit_index", bus.hit_index, 0);
    n = 0;
    repeat (70) begin
      @(negedge Clk);
      if (bus.scan_done) n++;
    end
    chk("t6_rst_idle", n, 0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 11; c++) begin
        frame(10'(104 + 32 * c), 10'(54 + 24 * r), 1'b1, n);
        add(pts(r));
        chk($sformatf("kill_latency_%0d", r * 11 + c), n, 5 + r * 11 + c);
        chk($sformatf("kill_index_%0d", r * 11 + c), bus.hit_index, r * 11 + c);
      end
    chk("kill_score", bus.score, es);
    chk("kill_alive", bus.alive, 0);
    chk("kill_all_dead", bus.all_dead, 1);
    @(negedge Clk);
    bus.pmX = 10'd0;
    bus.pmY = 10'd0;
    bus.frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (8) @(negedge Clk);
    bus.level_restart = 1'b1;
    @(negedge Clk);
    bus.level_restart = 1'b0;
    chk("t6_pending_alive", bus.alive, 0);
    n = 0;
    while (!bus.scan_done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("t6_pending_done_seen", n < 200, 1);
    repeat (2) @(negedge Clk);
    chk("t6_revive_alive", bus.alive, ea);
    chk("t6_revive_all_dead", bus.all_dead, 0);
    chk("t6_revive_score", bus.score, es);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
